// File: rtl/param_descrambler_pkg.sv
// Shared definitions for the parameterised descrambler: state encodings,
// keystream tap positions, default seed and the data width legality check.

`ifndef PARAM_DESCRAMBLER_PKG_SV
`define PARAM_DESCRAMBLER_PKG_SV

// True when a data width lies in the supported 1..16 range.
`define PD_WIDTH_OK(w) ((((w) >= 1) && ((w) <= 16)))

package param_descrambler_pkg;

  // Frame synchronisation states: HUNT waits for a start-of-frame,
  // RUN descrambles every accepted beat.
  typedef enum logic {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Default keystream register length.
  localparam int DEFAULT_LFSR_LEN = 7;

  // Tap positions counted down from the register MSB: bits LEN-1 and LEN-2.
  localparam int TAP_HI_FROM_MSB = 0;
  localparam int TAP_LO_FROM_MSB = 1;

  // Default load value, matching the transmit-side scrambler.
  localparam logic [DEFAULT_LFSR_LEN-1:0] DEFAULT_SEED = 7'h7F;

endpackage

`endif

// File: rtl/param_descrambler_lfsr.sv
// Combinational N-step advance of the Fibonacci keystream register.
// Bit i of the key is the feedback bit produced by step i.

module descr_lfsr
  import param_descrambler_pkg::*;
#(
  parameter int LFSR_LEN = DEFAULT_LFSR_LEN,
  parameter int N        = 2
) (
  input  logic [LFSR_LEN-1:0] i_state,
  output logic [LFSR_LEN-1:0] o_next,
  output logic [N-1:0]        o_key
);

  logic [LFSR_LEN-1:0] w_work;
  logic [N-1:0]        w_key;
  logic                w_fb;

  // Unroll N shift steps, collecting each feedback bit as one key bit.
  always_comb begin
    w_work = i_state;
    w_key  = '0;
    w_fb   = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_fb     = w_work[LFSR_LEN-1-TAP_HI_FROM_MSB] ^ w_work[LFSR_LEN-1-TAP_LO_FROM_MSB];
      w_key[i] = w_fb;
      w_work   = {w_work[LFSR_LEN-2:0], w_fb};
    end
  end

  assign o_next = w_work;
  assign o_key  = w_key;

endmodule

// File: rtl/param_descrambler.sv
// Receive-side descrambler: strips an additive LFSR keystream from framed
// words, re-seeding on every start-of-frame, behind a single registered
// valid/ready output stage.

module param_descrambler
  import param_descrambler_pkg::*;
#(
  parameter int                  WIDTH    = 2,
  parameter int                  LFSR_LEN = DEFAULT_LFSR_LEN,
  parameter logic [LFSR_LEN-1:0] SEED     = LFSR_LEN'(DEFAULT_SEED)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       frame_cnt,
  output logic             err_nosync
);

  // An all-zero seed would lock the register at zero, so it loads 1 instead.
  localparam logic [LFSR_LEN-1:0] SEED_VAL = (SEED == '0) ? LFSR_LEN'(1) : SEED;

  if (!`PD_WIDTH_OK(WIDTH)) begin : gWidthCheck
    $error("param_descrambler: WIDTH must be within 1..16");
  end

  state_t              r_state;
  state_t              w_nextState;
  logic [LFSR_LEN-1:0] r_lfsr;
  logic [LFSR_LEN-1:0] w_lfsrBase;
  logic [LFSR_LEN-1:0] w_lfsrNext;
  logic [WIDTH-1:0]    w_key;
  logic                w_accept;
  logic                w_produce;
  logic                w_drop;

  logic                r_outValid;
  logic                r_outSof;
  logic [WIDTH-1:0]    r_outData;
  logic [7:0]          r_frameCnt;
  logic                r_errNosync;

  // The input side may move whenever the output slot is empty or being popped.
  assign in_ready = !r_outValid || out_ready;

  descr_lfsr #(
    .LFSR_LEN (LFSR_LEN),
    .N        (WIDTH)
  ) uLfsr (
    .i_state (w_lfsrBase),
    .o_next  (w_lfsrNext),
    .o_key   (w_key)
  );

  // Hold the synchronisation state; reset always returns to HUNT.
  always_ff @(posedge clock) begin
    if (reset) r_state <= HUNT;
    else       r_state <= w_nextState;
  end

  // Classify the accepted beat and pick the keystream origin (seed on SOF).
  always_comb begin
    w_nextState = r_state;
    w_accept    = in_valid && in_ready;
    w_produce   = 1'b0;
    w_drop      = 1'b0;
    w_lfsrBase  = r_lfsr;
    if (w_accept) begin
      if (in_sof) begin
        w_nextState = RUN;
        w_produce   = 1'b1;
        w_lfsrBase  = SEED_VAL;
      end else if (r_state == RUN) begin
        w_produce   = 1'b1;
      end else begin
        w_drop      = 1'b1;
      end
    end
  end

  // Output stage, keystream register, frame counter and sync-error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_outValid  <= 1'b0;
      r_outSof    <= 1'b0;
      r_outData   <= '0;
      r_frameCnt  <= '0;
      r_errNosync <= 1'b0;
      r_lfsr      <= SEED_VAL;
    end else begin
      r_errNosync <= w_drop;
      if (w_produce) begin
        r_outValid <= 1'b1;
        r_outSof   <= in_sof;
        r_outData  <= in_data ^ w_key;
        r_lfsr     <= w_lfsrNext;
      end else if (out_ready) begin
        r_outValid <= 1'b0;
      end
      if (w_accept && in_sof) begin
        r_frameCnt <= r_frameCnt + 8'd1;
      end
    end
  end

  assign out_valid  = r_outValid;
  assign out_sof    = r_outSof;
  assign out_data   = r_outData;
  assign frame_cnt  = r_frameCnt;
  assign err_nosync = r_errNosync;

endmodule

// File: tb/tb_param_descrambler.sv
// Self-checking bench for param_descrambler: table vectors, hand-written
// corner sequences and randomized traffic against a beat-index keystream model.

module tb_param_descrambler;

  logic       clock;
  logic       reset;
  logic       in_valid, in_ready, in_sof;
  logic [1:0] in_data;
  logic       out_valid, out_ready, out_sof;
  logic [1:0] out_data;
  logic [7:0] frame_cnt;
  logic       err_nosync;

  logic       v1, rdy1, sof1, ov1, ordy1, osof1, err1;
  logic [0:0] d1, od1;
  logic [7:0] fc1;

  int nCompared   = 0;
  int nMismatched = 0;

  bit mSynced;
  bit mValid;
  int mData;
  bit mSof;
  int mFrame;
  bit mErr;
  int mBeat;

  typedef struct {
    bit       rst;
    bit       v;
    bit       sof;
    bit [1:0] data;
    bit       ordy;
    bit       expValid;
    bit [1:0] expData;
    bit       expSof;
    int       expFrame;
    bit       expErr;
  } vec_t;

  vec_t vecs[$];

  param_descrambler dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sof     (in_sof),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sof    (out_sof),
    .out_data   (out_data),
    .frame_cnt  (frame_cnt),
    .err_nosync (err_nosync)
  );

  param_descrambler #(.WIDTH(1)) dutW1 (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (v1),
    .in_ready   (rdy1),
    .in_sof     (sof1),
    .in_data    (d1),
    .out_valid  (ov1),
    .out_ready  (ordy1),
    .out_sof    (osof1),
    .out_data   (od1),
    .frame_cnt  (fc1),
    .err_nosync (err1)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Key for beat number 'beat' of a frame: skip beat*width steps from the seed.
  function automatic int keyAt(input int width, input int beat);
    int s   = 'h7F;
    int key = 0;
    int fb;
    for (int i = 0; i < beat * width; i++) begin
      fb = ((s >> 6) ^ (s >> 5)) & 1;
      s  = ((s << 1) | fb) & 'h7F;
    end
    for (int i = 0; i < width; i++) begin
      fb  = ((s >> 6) ^ (s >> 5)) & 1;
      key = key | (fb << i);
      s   = ((s << 1) | fb) & 'h7F;
    end
    return key;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mSynced = 0; mValid = 0; mData = 0; mSof = 0; mFrame = 0; mErr = 0; mBeat = 0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    in_valid = 0; in_sof = 0; in_data = 0; out_ready = 0;
    v1 = 0; sof1 = 0; d1 = 0; ordy1 = 1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
  endtask

  // Drive one cycle from a falling edge, predict the next output state.
  task automatic applyStimulus(input bit v, input bit sof, input bit [1:0] data, input bit ordy);
    bit rdyExp;
    bit acc;
    in_valid = v; in_sof = sof; in_data = data; out_ready = ordy;
    #1;
    rdyExp = !mValid || ordy;
    check("in_ready", {31'b0, in_ready}, {31'b0, rdyExp});
    acc  = v && rdyExp;
    mErr = 0;
    if (acc && sof) begin
      mSynced = 1; mValid = 1; mSof = 1;
      mData   = (data ^ keyAt(2, 0)) & 3;
      mBeat   = 1;
      mFrame  = (mFrame + 1) % 256;
    end else if (acc && mSynced) begin
      mValid = 1; mSof = 0;
      mData  = (data ^ keyAt(2, mBeat)) & 3;
      mBeat++;
    end else begin
      if (acc) mErr = 1;
      if (ordy) mValid = 0;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkOutput();
    check("out_valid", {31'b0, out_valid}, {31'b0, mValid});
    if (mValid) begin
      check("out_data", {30'b0, out_data}, mData);
      check("out_sof", {31'b0, out_sof}, {31'b0, mSof});
    end
    check("frame_cnt", {24'b0, frame_cnt}, mFrame);
    check("err_nosync", {31'b0, err_nosync}, {31'b0, mErr});
  endtask

  initial begin
    int w1Data[7];
    int w1Exp[7];

    // Table: default-width first frame, then non-SOF beats in HUNT.
    vecs.push_back('{1, 1, 1, 2'b11, 1, 1, 2'b11, 1, 1, 0});
    vecs.push_back('{0, 1, 0, 2'b00, 1, 1, 2'b00, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 2'b00, 1, 1, 2'b00, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 2'b00, 1, 1, 2'b01, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 1, 0});
    vecs.push_back('{1, 1, 0, 2'b10, 1, 0, 2'b00, 0, 0, 1});
    vecs.push_back('{0, 1, 0, 2'b01, 1, 0, 2'b00, 0, 0, 1});
    vecs.push_back('{0, 1, 0, 2'b11, 1, 0, 2'b00, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 2'b00, 1, 0, 2'b00, 0, 0, 0});

    doReset();
    $display("[TB] reset state");
    checkOutput();

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].v, vecs[i].sof, vecs[i].data, vecs[i].ordy);
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].expValid});
      if (vecs[i].expValid) begin
        check($sformatf("vec%0d_data", i), {30'b0, out_data}, {30'b0, vecs[i].expData});
        check($sformatf("vec%0d_sof", i), {31'b0, out_sof}, {31'b0, vecs[i].expSof});
      end
      check($sformatf("vec%0d_frame", i), {24'b0, frame_cnt}, vecs[i].expFrame);
      check($sformatf("vec%0d_err", i), {31'b0, err_nosync}, {31'b0, vecs[i].expErr});
    end

    $display("[TB] backpressure mid-frame");
    doReset();
    applyStimulus(1, 1, 2'($urandom), 1); checkOutput();
    applyStimulus(1, 0, 2'($urandom), 1); checkOutput();
    applyStimulus(1, 0, 2'($urandom), 1); checkOutput();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 2'($urandom), 0);
      checkOutput();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 2'($urandom), 1);
      checkOutput();
    end

    $display("[TB] resync SOF in RUN");
    doReset();
    applyStimulus(1, 1, 2'b01, 1); checkOutput();
    applyStimulus(1, 0, 2'b10, 1); checkOutput();
    applyStimulus(1, 1, 2'b10, 1); checkOutput();
    check("resync_data", {30'b0, out_data}, 32'd2);
    check("resync_frame", {24'b0, frame_cnt}, 32'd2);

    $display("[TB] frame counter wrap");
    doReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1, 1, 2'($urandom), 1);
      if (i == 254) check("frame_255", {24'b0, frame_cnt}, 32'd255);
    end
    check("frame_wrap", {24'b0, frame_cnt}, 32'd0);

    $display("[TB] reset while output is held");
    doReset();
    applyStimulus(1, 1, 2'b10, 0); checkOutput();
    applyStimulus(1, 0, 2'b01, 0); checkOutput();
    doReset();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    applyStimulus(1, 0, 2'b01, 1);
    check("rst_hunt_err", {31'b0, err_nosync}, 32'd1);
    check("rst_hunt_valid", {31'b0, out_valid}, 32'd0);

    $display("[TB] randomized traffic");
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                    2'($urandom), $urandom_range(0, 9) < 7);
      checkOutput();
    end

    $display("[TB] WIDTH=1 instance first frame");
    doReset();
    w1Data = '{1, 0, 0, 0, 0, 0, 0};
    w1Exp  = '{1, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 7; i++) begin
      v1   = 1'b1;
      sof1 = (i == 0);
      d1   = 1'(w1Data[i]);
      @(posedge clock);
      @(negedge clock);
      check($sformatf("w1_valid%0d", i), {31'b0, ov1}, 32'd1);
      check($sformatf("w1_data%0d", i), {31'b0, od1}, w1Exp[i]);
    end
    v1 = 1'b0;
    check("w1_frame", {24'b0, fc1}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
